sim_ctrl_resp: RTL and testbench
================================

# sim_ctrl_resp

Memory-mapped simulation-control responder on the core's data bus. The test program writes a result code and console characters here. The block drains buffered characters to a byte stream, then raises `sim_finish_o` with a pass/fail verdict for the testbench. It is the device-side end of the finish/verdict handshake the testbench waits on, replacing register peeking with an explicit bus protocol.

## Interface
- `BASE_ADDR`, 32'h9000_0000: base of the 32-byte register window; matched on `req_addr_i[31:5]`.
- `FIFO_DEPTH`, 8: console FIFO entries; a power of two, at least 2.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, **asynchronous and active-high**.
- `req_valid_i` in 1: bus request valid.
- `req_addr_i` in 32: byte address.
- `req_wr_i` in 4: byte write strobes; 0 = read.
- `req_data_i` in 32: write data.
- `req_accept_o` out 1: request taken this cycle.
- `resp_ack_o` out 1: response valid, one cycle after accept.
- `resp_data_o` out 32: read data; 0 on writes.
- `tx_valid_o` out 1: console byte valid.
- `tx_data_o` out 8: console byte.
- `tx_ready_i` in 1: console sink ready.
- `sim_finish_o` out 1: simulation finished.
- `sim_pass_o` out 1: the result code equals 1.
- `sim_code_o` out 32: the latched result code.

## Operation
- Register offsets are taken from `req_addr_i[4:2]`:
  - 0x00 FINISH: write latches `req_data_i` as the code. Reads return the code.
  - 0x04 STATUS: read-only. Bits are {fifo_count[7:0] @[15:8], state[1:0] @[1:0]}.
  - 0x08 PUTC: a write pushes `req_data_i[7:0]`. Reads return 0.
  - 0x0C ID: read-only, returns 32'h5343_0001.
  - 0x10 CYCLE_LO and 0x14 CYCLE_HI: present only with the macro.
  - Any other offset: reads return 0, writes are ignored.
- Requests outside the window are not accepted.
- `req_accept_o` = `req_valid_i` AND in-window AND NOT (PUTC write AND FIFO full AND state==RUN).
- State machine (2-bit):
  - RUN (0) → DRAIN (1) on an accepted FINISH write.
  - DRAIN → DONE (2) when the FIFO is empty and `tx_valid_o` is 0.
  - DONE is terminal until reset.
- Writes in DRAIN or DONE:
  - FINISH writes are acknowledged and ignored; the first code wins.
  - PUTC writes are acknowledged and discarded.
- FIFO rules:
  - A push occurs only in RUN.
  - A pop occurs when `tx_valid_o` is 1 and `tx_ready_i` is 1.
  - `tx_valid_o` = FIFO not empty; `tx_data_o` = the head entry. This is first-word fall-through.
  - On a simultaneous push and pop the count is unchanged. A push while full is impossible because accept is low.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2+1 bits.
- Outputs:
  - `sim_finish_o` = (state==DONE).
  - `sim_pass_o` = DONE AND code==1.
  - `sim_code_o` = the latched code at all times.

## Timing
- Accept is combinational from request inputs and the FIFO/state registers.
- `resp_ack_o` and `resp_data_o` are registered, one cycle after accept. Back-to-back requests sustain one per cycle.
- A PUTC write accepted in cycle N makes its byte visible on `tx_*` in cycle N+1.
- A FINISH write accepted in cycle N with an empty FIFO gives DRAIN at N+1, DONE at N+2, and `sim_finish_o` high at N+2.
- Reset state: all outputs 0, FIFO empty, state RUN, code 0.
- Reset during DRAIN discards pending bytes and returns to RUN. There is no partial byte transfer.

## Configuration
- `SIM_CTRL_CYCLE_CNT_EN` defined:
  - A 64-bit free-running counter runs from reset, starting at 0.
  - It freezes when DONE is entered.
  - A CYCLE_LO read snapshots the high word. A CYCLE_HI read returns the snapshot, giving a coherent 64-bit read.
- Undefined: the counter is absent, offsets 0x10 and 0x14 read as 0, and the snapshot logic is removed.

## Structure
- Shared package `sim_ctrl_pkg` holds:
  - the register offset constants;
  - the ID value;
  - the state enum {RUN, DRAIN, DONE};
  - the pass code constant (1).
- One sub-module, `sim_ctrl_fifo`: parameterised-depth, first-word fall-through byte FIFO with push/pop/full/empty/count.
- The top level contains address decode, the response register, the FSM and the optional counter.

## Test plan
- Reset release, then read ID at 0x0C: ack 1 cycle later, data 32'h5343_0001. All of `tx_valid_o`, `sim_finish_o` and `sim_pass_o` are 0.
- PUTC 'O','K','\n' with `tx_ready_i`=1: bytes 0x4F, 0x4B, 0x0A appear in order on consecutive cycles, each one cycle after its accept.
- `tx_ready_i`=0, then 9 PUTC writes with the default depth:
  - the first 8 are accepted and STATUS shows a count of 8;
  - the 9th stalls (accept 0) until `tx_ready_i`=1 frees an entry.
- 3 bytes queued, `tx_ready_i`=0, FINISH write 32'h1:
  - state goes to DRAIN and `sim_finish_o` stays 0;
  - after 3 ready cycles, `sim_finish_o`=1 and `sim_pass_o`=1 two cycles after the FIFO empties.
- FINISH write 32'h7, then FINISH write 32'h1: `sim_code_o`=7 and `sim_pass_o`=0. A PUTC in DONE is acked and produces no `tx_valid_o`.
- With `SIM_CTRL_CYCLE_CNT_EN`: read LO then HI across a 32-bit rollover (force the counter to 32'hFFFF_FFFE low). The HI value matches the snapshot taken at the LO read. Reset during DRAIN gives RUN, an empty FIFO and code 0.

Source files
------------

// File: rtl/sim_ctrl_pkg.sv
// Shared constants and types for the simulation-control responder.
// Register map, ID value, verdict code and the run/drain/done state enum.
package sim_ctrl_pkg;

  localparam logic [2:0] OFF_FINISH = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_PUTC   = 3'd2;
  localparam logic [2:0] OFF_ID     = 3'd3;
  localparam logic [2:0] OFF_CYC_LO = 3'd4;
  localparam logic [2:0] OFF_CYC_HI = 3'd5;

  localparam logic [31:0] ID_VALUE  = 32'h5343_0001;
  localparam logic [31:0] PASS_CODE = 32'd1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// First-word fall-through byte FIFO for the console stream.
// Power-of-two depth; pointers wrap naturally, count is one bit wider.
module sim_ctrl_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sim_ctrl_resp.sv
// Simulation-control responder: result code, console FIFO, finish verdict.
// Optional 64-bit cycle counter enabled by SIM_CTRL_CYCLE_CNT_EN.
module sim_ctrl_resp
  import sim_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_wr_i,
  input  logic [31:0] req_data_i,
  output logic        req_accept_o,
  output logic        resp_ack_o,
  output logic [31:0] resp_data_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        sim_finish_o,
  output logic        sim_pass_o,
  output logic [31:0] sim_code_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   code_q;
  logic          in_win;
  logic          wr;
  logic [2:0]    off;
  logic          wr_hit;
  logic          push;
  logic          pop;
  logic          fin;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   status;
  logic [31:0]   rd_data;
  logic [31:0]   cyc_lo;
  logic [31:0]   cyc_hi;
  logic          unused;

  assign unused = ^req_addr_i[1:0];

  assign wr     = |req_wr_i;
  assign off    = req_addr_i[4:2];
  assign in_win = (req_addr_i[31:5] == BASE_ADDR[31:5]);

  // Only a live push can back-pressure; late PUTCs are swallowed.
  assign req_accept_o = req_valid_i & in_win &
    ~(wr & (off == OFF_PUTC) & full & (state_q == ST_RUN));

  assign wr_hit = req_accept_o & wr;
  assign push   = wr_hit & (off == OFF_PUTC) & (state_q == ST_RUN);
  assign fin    = wr_hit & (off == OFF_FINISH) & (state_q == ST_RUN);
  assign pop    = tx_valid_o & tx_ready_i;

  sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (req_data_i[7:0]),
    .pop       (pop),
    .head      (tx_data_o),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign tx_valid_o = ~empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (fin)   state_d = ST_DRAIN;
      ST_DRAIN: if (empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    sim_finish_o = (state_q == ST_DONE);
    sim_pass_o   = (state_q == ST_DONE) && (code_q == PASS_CODE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    code_q <= '0;
    else if (fin) code_q <= req_data_i;
  end

  assign sim_code_o = code_q;

`ifdef SIM_CTRL_CYCLE_CNT_EN
  logic [63:0] cycle_q;
  logic [31:0] snap_q;

  // A LO read captures HI so the pair reads coherently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q <= '0;
      snap_q  <= '0;
    end else begin
      if (state_q != ST_DONE) cycle_q <= cycle_q + 64'd1;
      if (req_accept_o && !wr && off == OFF_CYC_LO)
        snap_q <= cycle_q[63:32];
    end
  end

  assign cyc_lo = cycle_q[31:0];
  assign cyc_hi = snap_q;
`else
  assign cyc_lo = '0;
  assign cyc_hi = '0;
`endif

  assign status = {16'h0, 8'(count), 6'h0, state_q};

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_FINISH: rd_data = code_q;
      OFF_STATUS: rd_data = status;
      OFF_ID:     rd_data = ID_VALUE;
      OFF_CYC_LO: rd_data = cyc_lo;
      OFF_CYC_HI: rd_data = cyc_hi;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_ack_o  <= 1'b0;
      resp_data_o <= '0;
    end else begin
      resp_ack_o  <= req_accept_o;
      resp_data_o <= (req_accept_o && !wr) ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_sim_ctrl_resp.sv
// Bench for sim_ctrl_resp: directed table, corner sequences, random vs model.
// Cycle-counter reads are exercised when SIM_CTRL_CYCLE_CNT_EN is defined.
module tb_sim_ctrl_resp;

  localparam logic [31:0] BASE  = 32'h9000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_wr = '0;
  logic [31:0] req_data = '0;
  logic        req_accept;
  logic        resp_ack;
  logic [31:0] resp_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        sim_finish;
  logic        sim_pass;
  logic [31:0] sim_code;

  sim_ctrl_resp #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_wr_i     (req_wr),
    .req_data_i   (req_data),
    .req_accept_o (req_accept),
    .resp_ack_o   (resp_ack),
    .resp_data_o  (resp_data),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .sim_finish_o (sim_finish),
    .sim_pass_o   (sim_pass),
    .sim_code_o   (sim_code)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue, phase 0/1/2, code, pending response.
  logic [7:0]  mq[$];
  int          mst;
  logic [31:0] mcode;
  bit          mack;
  logic [31:0] mrd;
  bit          mrd_known;

  bit          c_acc;
  bit          c_wr;
  int          c_off;
  logic [31:0] c_d;
  bit          c_rdy;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] d;
    bit          rdy;
    bit          e_acc;
    bit          e_txv;
    logic [7:0]  e_txd;
    bit          e_ack;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_wr = '0;
    req_data = '0;
    tx_ready = 1'b0;
    mq.delete();
    mst = 0;
    mcode = '0;
    mack = 1'b0;
    mrd = '0;
    mrd_known = 1'b1;
    #2;
    chk("rst_accept", req_accept, 0);
    chk("rst_ack", resp_ack, 0);
    chk("rst_rdata", resp_data, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_finish", sim_finish, 0);
    chk("rst_pass", sim_pass, 0);
    chk("rst_code", sim_code, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one request, then compare every output against the model.
  task automatic drive_check(input bit v, input logic [31:0] a,
                             input logic [3:0] w, input logic [31:0] d,
                             input bit rdy);
    bit inwin;
    req_valid = v;
    req_addr = a;
    req_wr = w;
    req_data = d;
    tx_ready = rdy;
    #2;
    inwin = (a >= BASE) && (a < BASE + 32'd32);
    c_off = int'(a[4:2]);
    c_wr = (w != 4'h0);
    c_d = d;
    c_rdy = rdy;
    c_acc = v && inwin &&
            !(c_wr && c_off == 2 && mq.size() == DEPTH && mst == 0);
    chk("accept", req_accept, c_acc);
    chk("tx_valid", tx_valid, mq.size() != 0);
    if (mq.size() != 0) chk("tx_data", tx_data, mq[0]);
    chk("resp_ack", resp_ack, mack);
    if (mrd_known) chk("resp_data", resp_data, mrd);
    chk("finish", sim_finish, mst == 2);
    chk("pass", sim_pass, mst == 2 && mcode == 32'd1);
    chk("code", sim_code, mcode);
  endtask

  task automatic advance();
    logic [31:0] rd;
    bit known;
    bit was_empty;
    rd = '0;
    known = 1'b1;
    if (c_acc && !c_wr) begin
      case (c_off)
        0: rd = mcode;
        1: rd = 32'(mq.size() * 256 + mst);
        3: rd = 32'h5343_0001;
`ifdef SIM_CTRL_CYCLE_CNT_EN
        4, 5: known = 1'b0;
`endif
        default: rd = '0;
      endcase
    end
    mack = c_acc;
    mrd = rd;
    mrd_known = known;
    was_empty = (mq.size() == 0);
    if (!was_empty && c_rdy) void'(mq.pop_front());
    if (c_acc && c_wr && c_off == 2 && mst == 0) mq.push_back(c_d[7:0]);
    if (mst == 0 && c_acc && c_wr && c_off == 0) begin
      mcode = c_d;
      mst = 1;
    end else if (mst == 1 && was_empty) begin
      mst = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit v, input logic [31:0] a, input logic [3:0] w,
                    input logic [31:0] d, input bit rdy);
    drive_check(v, a, w, d, rdy);
    advance();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, BASE + 32'hC, 4'h0, 32'h0,  1, 1, 0, 8'h00, 0, 32'h0};
    tv[1] = '{1, BASE + 32'h8, 4'hF, 32'h4F, 1, 1, 0, 8'h00, 1, 32'h5343_0001};
    tv[2] = '{1, BASE + 32'h8, 4'hF, 32'h4B, 1, 1, 1, 8'h4F, 1, 32'h0};
    tv[3] = '{1, BASE + 32'h8, 4'hF, 32'h0A, 1, 1, 1, 8'h4B, 1, 32'h0};
    tv[4] = '{1, BASE + 32'h4, 4'h0, 32'h0,  1, 1, 1, 8'h0A, 1, 32'h0};
    tv[5] = '{0, 32'h0,        4'h0, 32'h0,  1, 0, 0, 8'h00, 1, 32'h100};
    tv[6] = '{1, 32'h8000_000C, 4'h0, 32'h0, 1, 0, 0, 8'h00, 0, 32'h0};
    tv[7] = '{1, BASE,         4'h0, 32'h0,  1, 1, 0, 8'h00, 0, 32'h0};
    tv[8] = '{0, 32'h0,        4'h0, 32'h0,  1, 0, 0, 8'h00, 1, 32'h0};

    #1;
    reset_dut();

    for (int i = 0; i < 9; i++) begin
      drive_check(tv[i].v, tv[i].a, tv[i].w, tv[i].d, tv[i].rdy);
      chk($sformatf("tbl%0d_acc", i), req_accept, tv[i].e_acc);
      chk($sformatf("tbl%0d_txv", i), tx_valid, tv[i].e_txv);
      if (tv[i].e_txv) chk($sformatf("tbl%0d_txd", i), tx_data, tv[i].e_txd);
      chk($sformatf("tbl%0d_ack", i), resp_ack, tv[i].e_ack);
      chk($sformatf("tbl%0d_rd", i), resp_data, tv[i].e_rd);
      advance();
    end

    // Fill to depth with the sink stalled, then overflow attempt.
    for (int i = 0; i < 8; i++) begin
      drive_check(1, BASE + 32'h8, 4'hF, 32'h30 + i, 0);
      chk("fill_acc", req_accept, 1);
      advance();
    end
    op(1, BASE + 32'h4, 4'h0, 0, 0);
    drive_check(0, 0, 0, 0, 0);
    chk("status_cnt8", resp_data, 32'h0000_0800);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive_check(1, BASE + 32'h8, 4'hF, 32'h39, 0);
      chk("full_stall", req_accept, 0);
      advance();
    end
    begin
      int k = 0;
      bit got = 0;
      while (!got && k < 4) begin
        drive_check(1, BASE + 32'h8, 4'hF, 32'h39, 1);
        got = req_accept;
        advance();
        k++;
      end
      chk("unstall_acc", got, 1);
      chk("unstall_cycles", k, 2);
    end
    for (int i = 0; i < 12; i++) op(0, 0, 0, 0, 1);

    // Drain with pass code.
    reset_dut();
    op(1, BASE + 32'h8, 4'hF, 32'h61, 0);
    op(1, BASE + 32'h8, 4'hF, 32'h62, 0);
    op(1, BASE + 32'h8, 4'hF, 32'h63, 0);
    op(1, BASE, 4'hF, 32'h1, 0);
    op(1, BASE + 32'h4, 4'h0, 0, 0);
    drive_check(0, 0, 0, 0, 0);
    chk("drain_status", resp_data, 32'h0000_0301);
    chk("drain_nofin", sim_finish, 0);
    advance();
    for (int i = 0; i < 5; i++) begin
      drive_check(0, 0, 0, 0, 1);
      chk("drain_fin_t", sim_finish, i >= 4);
      advance();
    end
    drive_check(0, 0, 0, 0, 1);
    chk("final_pass", sim_pass, 1);
    advance();

    // First code wins; PUTC in DONE is acked but dropped.
    reset_dut();
    op(1, BASE, 4'hF, 32'h7, 1);
    op(1, BASE, 4'hF, 32'h1, 1);
    drive_check(1, BASE + 32'h8, 4'hF, 32'h41, 1);
    chk("done_code", sim_code, 32'h7);
    chk("done_fin", sim_finish, 1);
    chk("done_pass", sim_pass, 0);
    chk("done_putc_acc", req_accept, 1);
    advance();
    drive_check(0, 0, 0, 0, 1);
    chk("done_putc_ack", resp_ack, 1);
    chk("done_putc_txv", tx_valid, 0);
    advance();

    // Reset while draining.
    reset_dut();
    op(1, BASE + 32'h8, 4'hF, 32'h31, 0);
    op(1, BASE + 32'h8, 4'hF, 32'h32, 0);
    op(1, BASE + 32'h8, 4'hF, 32'h33, 0);
    op(1, BASE, 4'hF, 32'h5, 0);
    op(0, 0, 0, 0, 0);
    reset_dut();
    op(1, BASE + 32'h4, 4'h0, 0, 0);
    drive_check(0, 0, 0, 0, 0);
    chk("rst_drain_status", resp_data, 32'h0);
    chk("rst_drain_txv", tx_valid, 0);
    advance();

`ifdef SIM_CTRL_CYCLE_CNT_EN
    begin
      logic [31:0] lo;
      op(1, BASE + 32'h10, 4'h0, 0, 1);
      drive_check(1, BASE + 32'h14, 4'h0, 0, 1);
      lo = resp_data;
      chk("cyc_lo_run", lo != 0, 1);
      advance();
      drive_check(0, 0, 0, 0, 1);
      chk("cyc_hi_snap", resp_data, 32'h0);
      advance();
    end
`endif

    // Randomised traffic against the model.
    for (int seg = 0; seg < 4; seg++) begin
      reset_dut();
      for (int n = 0; n < 250; n++) begin
        bit          v;
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        int          o;
        v = ($urandom_range(3) != 0);
        o = ($urandom_range(9) < 5) ? 2 : int'($urandom_range(7));
`ifdef SIM_CTRL_CYCLE_CNT_EN
        if (o == 4 || o == 5) o = o + 2;
`endif
        a = BASE + 32'(o * 4) + 32'($urandom_range(3));
        if ($urandom_range(9) == 0) a = a ^ 32'h0100_0000;
        w = ($urandom_range(1) == 0) ? 4'h0 : 4'(1 + $urandom_range(14));
        if (o == 0 && w != 0 && $urandom_range(39) != 0) w = 4'h0;
        d = ($urandom_range(1) == 0) ? 32'h1 : $urandom;
        op(v, a, w, d, $urandom_range(2) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
